// File: rtl/ctrl_decode_stage.sv
// Registered RV64 main-control decode stage with valid/ready handshake.
// M-extension ops are held in a countdown state for a programmable latency before being presented.
module ctrl_decode_stage #(
  parameter int ENABLE_M = 1,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        regWrite,
  output logic        aluSrc,
  output logic        aluSext,
  output logic        memRead,
  output logic        memWrite,
  output logic        branch,
  output logic        jump,
  output logic        jumpReg,
  output logic        lui,
  output logic        auipc,
  output logic        csrrx,
  output logic [1:0]  aluOp,
  output logic        mulDiv,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [12:0]        ctrl_q, ctrl_d;
  logic               mul_div_q, mul_div_d;
  logic               illegal_q, illegal_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [31:0]        out_instr_q, out_instr_d;

  logic [12:0]        dec_ctrl;
  logic               dec_illegal;
  logic               dec_mul;
  logic               dec_multi;
  logic [CNT_W-1:0]   dec_lat;
  logic               accept;

  // Bundle layout: {regWrite, aluSrc, aluOp[1:0], aluSext, memRead, memWrite, branch, jump, jumpReg, lui, auipc, csrrx}
  always_comb begin
    dec_ctrl    = 13'd0;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    case (instr[6:0])
      7'b0110011: dec_ctrl = 13'b1_0_10_0_0_0_0_0_0_0_0_0;
      7'b0111011: dec_ctrl = 13'b1_0_10_1_0_0_0_0_0_0_0_0;
      7'b0010011: dec_ctrl = 13'b1_1_11_0_0_0_0_0_0_0_0_0;
      7'b0011011: dec_ctrl = 13'b1_1_11_1_0_0_0_0_0_0_0_0;
      7'b0000011: dec_ctrl = 13'b1_1_00_0_1_0_0_0_0_0_0_0;
      7'b0100011: dec_ctrl = 13'b0_1_00_0_0_1_0_0_0_0_0_0;
      7'b1100011: dec_ctrl = 13'b0_0_01_0_0_0_1_0_0_0_0_0;
      7'b1101111: dec_ctrl = 13'b1_0_00_0_0_0_0_1_0_0_0_0;
      7'b1100111: dec_ctrl = 13'b1_1_00_0_0_0_0_0_1_0_0_0;
      7'b0110111: dec_ctrl = 13'b1_1_00_0_0_0_0_0_0_1_0_0;
      7'b0010111: dec_ctrl = 13'b1_1_00_0_0_0_0_0_0_0_1_0;
      7'b1110011: dec_ctrl = 13'b1_0_00_0_0_0_0_0_0_0_0_1;
      default:    dec_illegal = 1'b1;
    endcase
    if (((instr[6:0] == 7'b0110011) || (instr[6:0] == 7'b0111011)) &&
        (instr[31:25] == 7'b0000001)) begin
      if (ENABLE_M != 0) begin
        dec_mul = 1'b1;
      end else begin
        dec_ctrl    = 13'd0;
        dec_illegal = 1'b1;
      end
    end else begin
      dec_mul = 1'b0;
    end
  end

  // funct3[2] separates div/rem from mul; a latency of one needs no countdown
  assign dec_lat   = instr[14] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
  assign dec_multi = dec_mul && (dec_lat > CNT_W'(1));
  assign in_ready  = !flush && ((state_q == S_EMPTY) || ((state_q == S_HOLD) && out_ready));
  assign accept    = in_valid && in_ready;

  // Next-state, countdown and held-entry selection
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    mul_div_d   = mul_div_q;
    illegal_d   = illegal_q;
    out_instr_d = out_instr_q;
    if (flush) begin
      state_d   = S_EMPTY;
      cnt_d     = {CNT_W{1'b0}};
      mul_div_d = 1'b0;
      illegal_d = 1'b0;
    end else if (accept) begin
      ctrl_d      = dec_ctrl;
      mul_div_d   = dec_mul;
      illegal_d   = dec_illegal;
      out_instr_d = instr;
      if (dec_multi) begin
        state_d = S_WAIT;
        cnt_d   = dec_lat - CNT_W'(1);
      end else begin
        state_d = S_HOLD;
        cnt_d   = {CNT_W{1'b0}};
      end
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_HOLD;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_d = S_EMPTY;
          end else begin
            state_d = S_HOLD;
          end
        end
        default: state_d = state_q;
      endcase
    end
    out_valid_d = (state_d == S_HOLD);
    busy_d      = (state_d == S_WAIT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_EMPTY;
      cnt_q       <= {CNT_W{1'b0}};
      ctrl_q      <= 13'd0;
      mul_div_q   <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_instr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      mul_div_q   <= mul_div_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_instr_q <= out_instr_d;
    end
  end

  assign {regWrite, aluSrc, aluOp, aluSext, memRead, memWrite,
          branch, jump, jumpReg, lui, auipc, csrrx} = ctrl_q;
  assign mulDiv    = mul_div_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_instr = out_instr_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: default instance plus an ENABLE_M=0 instance.
module tb_ctrl_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_valid_nm;
  logic        out_ready;
  logic        out_ready_nm;
  logic [31:0] instr;

  logic        in_ready, out_valid, busy, mulDiv, illegal;
  logic [31:0] out_instr;
  logic        regWrite, aluSrc, aluSext, memRead, memWrite, branch, jump, jumpReg, lui, auipc, csrrx;
  logic [1:0]  aluOp;

  logic        in_ready_nm, out_valid_nm, busy_nm, mulDiv_nm, illegal_nm;
  logic [31:0] out_instr_nm;
  logic        regWrite_nm, aluSrc_nm, aluSext_nm, memRead_nm, memWrite_nm, branch_nm;
  logic        jump_nm, jumpReg_nm, lui_nm, auipc_nm, csrrx_nm;
  logic [1:0]  aluOp_nm;

  logic [12:0] ctrl_o, ctrl_nm;
  int          n_checks = 0;
  int          n_fail   = 0;

  assign ctrl_o  = {regWrite, aluSrc, aluOp, aluSext, memRead, memWrite,
                    branch, jump, jumpReg, lui, auipc, csrrx};
  assign ctrl_nm = {regWrite_nm, aluSrc_nm, aluOp_nm, aluSext_nm, memRead_nm, memWrite_nm,
                    branch_nm, jump_nm, jumpReg_nm, lui_nm, auipc_nm, csrrx_nm};

  always #5 clk = ~clk;

  ctrl_decode_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .regWrite(regWrite), .aluSrc(aluSrc), .aluSext(aluSext), .memRead(memRead),
    .memWrite(memWrite), .branch(branch), .jump(jump), .jumpReg(jumpReg),
    .lui(lui), .auipc(auipc), .csrrx(csrrx), .aluOp(aluOp),
    .mulDiv(mulDiv), .illegal(illegal), .busy(busy)
  );

  ctrl_decode_stage #(.ENABLE_M(0)) dut_nm (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid_nm), .in_ready(in_ready_nm), .instr(instr),
    .out_valid(out_valid_nm), .out_ready(out_ready_nm), .out_instr(out_instr_nm),
    .regWrite(regWrite_nm), .aluSrc(aluSrc_nm), .aluSext(aluSext_nm), .memRead(memRead_nm),
    .memWrite(memWrite_nm), .branch(branch_nm), .jump(jump_nm), .jumpReg(jumpReg_nm),
    .lui(lui_nm), .auipc(auipc_nm), .csrrx(csrrx_nm), .aluOp(aluOp_nm),
    .mulDiv(mulDiv_nm), .illegal(illegal_nm), .busy(busy_nm)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] vec_instr [10] = '{32'h00108113, 32'h00208033, 32'h002080BB, 32'h0010809B,
                                  32'h00208463, 32'h008000EF, 32'h000080E7, 32'h000010B7,
                                  32'h00001097, 32'h30001073};
  logic [12:0] vec_ctrl  [10] = '{13'h1E00, 13'h1400, 13'h1500, 13'h1F00,
                                  13'h0220, 13'h1010, 13'h1808, 13'h1804,
                                  13'h1802, 13'h1001};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int rises;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid_nm = 1'b0;
    out_ready = 1'b1; out_ready_nm = 1'b1; instr = 32'd0;
    #13;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ctrl", {19'd0, ctrl_o}, 32'd0);
    check_eq("rst_md_ill", {30'd0, mulDiv, illegal}, 32'd0);
    check_eq("rst_out_instr", out_instr, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // single addi
    instr = 32'h00500093; in_valid = 1'b1;
    #1 check_eq("addi_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("addi_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("addi_ctrl", {19'd0, ctrl_o}, 32'h1E00);
    check_eq("addi_out_instr", out_instr, 32'h00500093);
    tick();
    check_eq("addi_empty", {31'd0, out_valid}, 32'd0);

    // back-to-back stream, ALU ops first then the remaining opcode classes
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr = vec_instr[i];
      #1 check_eq($sformatf("stream%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      check_eq($sformatf("stream%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check_eq($sformatf("stream%0d_instr", i), out_instr, vec_instr[i]);
      check_eq($sformatf("stream%0d_ctrl", i), {19'd0, ctrl_o}, {19'd0, vec_ctrl[i]});
    end
    in_valid = 1'b0;
    tick();
    check_eq("stream_drain", {31'd0, out_valid}, 32'd0);

    // mul, latency 3
    instr = 32'h02208033; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("mul_w1_busy", {31'd0, busy}, 32'd1);
    check_eq("mul_w1_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mul_w1_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check_eq("mul_w2_busy", {31'd0, busy}, 32'd1);
    check_eq("mul_w2_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check_eq("mul_hold_valid", {31'd0, out_valid}, 32'd1);
    check_eq("mul_hold_busy", {31'd0, busy}, 32'd0);
    check_eq("mul_muldiv", {31'd0, mulDiv}, 32'd1);
    check_eq("mul_ctrl", {19'd0, ctrl_o}, 32'h1400);
    tick();
    check_eq("mul_drain", {31'd0, out_valid}, 32'd0);

    // div, latency 16, plus ENABLE_M=0 instance seeing the same word
    instr = 32'h0220C033; in_valid = 1'b1; in_valid_nm = 1'b1;
    tick();
    in_valid = 1'b0; in_valid_nm = 1'b0;
    check_eq("nm_valid", {31'd0, out_valid_nm}, 32'd1);
    check_eq("nm_illegal", {31'd0, illegal_nm}, 32'd1);
    check_eq("nm_muldiv_busy", {30'd0, mulDiv_nm, busy_nm}, 32'd0);
    check_eq("nm_ctrl", {19'd0, ctrl_nm}, 32'd0);
    check_eq("nm_instr", out_instr_nm, 32'h0220C033);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq("div_latency", n, 32'd15);
    check_eq("div_muldiv", {31'd0, mulDiv}, 32'd1);
    tick();
    check_eq("div_drain", {31'd0, out_valid}, 32'd0);

    // sw stalled for 5 cycles with lw pending, then released
    out_ready = 1'b0; instr = 32'h0020A023; in_valid = 1'b1;
    tick();
    instr = 32'h0000A103;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq($sformatf("stall%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check_eq($sformatf("stall%0d_ctrl", i), {19'd0, ctrl_o}, 32'h0840);
      check_eq($sformatf("stall%0d_instr", i), out_instr, 32'h0020A023);
      check_eq($sformatf("stall%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1 check_eq("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("lw_valid", {31'd0, out_valid}, 32'd1);
    check_eq("lw_instr", out_instr, 32'h0000A103);
    check_eq("lw_ctrl", {19'd0, ctrl_o}, 32'h1880);
    tick();

    // flush in 4th WAIT cycle of a div
    instr = 32'h0220C033; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check_eq("flush_pre_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    #1 check_eq("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    check_eq("flush_busy", {31'd0, busy}, 32'd0);
    check_eq("flush_md_ill", {30'd0, mulDiv, illegal}, 32'd0);
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) rises++;
      tick();
    end
    check_eq("flush_no_valid", rises, 32'd0);

    // opcode 0000000
    instr = 32'h00000000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("ill_valid", {31'd0, out_valid}, 32'd1);
    check_eq("ill_flag", {31'd0, illegal}, 32'd1);
    check_eq("ill_ctrl_md", {18'd0, ctrl_o, mulDiv}, 32'd0);
    tick();

    // async reset in the middle of a WAIT
    instr = 32'h02208033; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("ar_pre_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("ar_busy_valid", {30'd0, busy, out_valid}, 32'd0);
    check_eq("ar_out_instr", out_instr, 32'd0);
    check_eq("ar_ctrl_md", {18'd0, ctrl_o, mulDiv}, 32'd0);
    #1 reset_n = 1'b1;
    tick(); tick(); tick();
    check_eq("ar_stays_empty", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
